// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one 64-bit, one-command-per-cycle RAM port between the instruction
// fetch requester (if_*) and the load/store requester (mem_*). Only one
// transaction is in flight at a time. The RAM returns read data one cycle after
// the command, so every grant is followed by exactly one response cycle. That
// gives a peak rate of one transaction per two cycles.
//
// Arbitration is combinational in IDLE. The grant and the RAM command are
// issued in the same cycle. Data requests win by default.
//
// Optional build macro:
//   ARB_STARVE_GUARD_EN - adds a saturating counter of consecutive data grants
//                         made while fetch is waiting. Once the counter reaches
//                         STARVE_LIMIT, a pending fetch wins the next
//                         arbitration. Without the macro, data priority is
//                         strict and STARVE_LIMIT does not exist.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   if_req/if_addr      fetch request (held until if_gnt), 4-byte aligned
//   if_gnt              fetch accepted this cycle
//   if_rvalid/if_rdata  fetch response pulse and 32-bit instruction
//   mem_req/mem_we      data request (held until mem_gnt), 1 = store
//   mem_addr            data byte address, bits [2:0] ignored
//   mem_wdata/wmask     lane-aligned store data and byte enables
//   mem_gnt             data accepted this cycle
//   mem_rvalid/rdata    data response pulse (load word, or 0 for a store ack)
//   ram_en/ram_we       RAM command valid / write
//   ram_idx             word index = (addr - PC_START) >> 3, wraps mod 2^IDX_W
//   ram_wdata/wmask     write data and bit mask (byte enable replicated x8)
//   ram_rdata           RAM read data, valid one cycle after a read command
// -----------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] PC_START = ADDR_W'(64'h8000_0000),
  parameter int                IDX_W    = 24
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int                STARVE_LIMIT = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,

  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_wdata,
  input  logic [7:0]        mem_wmask,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [63:0]       mem_rdata,

  output logic              ram_en,
  output logic              ram_we,
  output logic [IDX_W-1:0]  ram_idx,
  output logic [63:0]       ram_wdata,
  output logic [63:0]       ram_wmask,
  input  logic [63:0]       ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESP_I = 2'd1,
    S_RESP_D = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_half_hi;       // fetch selected the upper 32-bit half
  logic              w_next_half_hi;
  logic              r_is_store;      // data transaction was a store
  logic              w_next_is_store;

  logic              w_idle;          // arbitration allowed this cycle
  logic              w_fetch_pri;     // fetch temporarily outranks data
  logic [ADDR_W-1:0] w_addr;          // address of the winning requester
  logic [ADDR_W-1:0] w_off;           // byte offset from PC_START

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_fetch_pri = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts data grants won while fetch was also waiting. A fetch grant, or
  // an IDLE cycle without a fetch request, breaks the run of data grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (if_gnt || !if_req) begin
        r_starve_cnt <= '0;
      end else if (mem_gnt && (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end
`else
  assign w_fetch_pri = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments, so every register
  // samples the values from before the edge, no matter the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_half_hi  <= 1'b0;
      r_is_store <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_half_hi  <= w_next_half_hi;
      r_is_store <= w_next_is_store;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, arbitration and outputs
  // ---------------------------------------------------------------------------
  // The grant path is combinational from the requests. While rst is high the
  // state is already IDLE, so IDLE is also qualified with !rst. This keeps
  // every output at 0 during reset.
  assign w_idle = (r_state == S_IDLE) && !rst;

  // NOTE: every signal written here gets a default first. An incomplete
  // assignment path in a combinational block would otherwise infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_next_half_hi  = r_half_hi;
    w_next_is_store = r_is_store;
    w_addr          = if_addr;

    if_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    ram_wmask  = '0;

    unique case (r_state)
      S_IDLE: begin
        if (w_idle) begin
          if (mem_req && !(if_req && w_fetch_pri)) begin
            mem_gnt         = 1'b1;
            ram_en          = 1'b1;
            ram_we          = mem_we;
            w_addr          = mem_addr;
            w_next_is_store = mem_we;
            w_next_state    = S_RESP_D;
            if (mem_we) begin
              ram_wdata = mem_wdata;
              for (int b = 0; b < 8; b++) begin
                ram_wmask[8*b +: 8] = {8{mem_wmask[b]}};
              end
            end
          end else if (if_req) begin
            if_gnt         = 1'b1;
            ram_en         = 1'b1;
            w_addr         = if_addr;
            w_next_half_hi = if_addr[2];
            w_next_state   = S_RESP_I;
          end
        end
      end

      S_RESP_I: begin
        // The RAM returns the whole 64-bit word. Instructions are 32-bit, so
        // the half is chosen by the address bit latched at grant time.
        if_rvalid    = 1'b1;
        if_rdata     = r_half_hi ? ram_rdata[63:32] : ram_rdata[31:0];
        w_next_state = S_IDLE;
      end

      S_RESP_D: begin
        // A store gets an acknowledge pulse with zero data. ram_rdata is
        // meaningless after a write command.
        mem_rvalid   = 1'b1;
        mem_rdata    = r_is_store ? 64'h0 : ram_rdata;
        w_next_state = S_IDLE;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // Base-relative word index. Addresses below PC_START wrap silently
    // modulo 2^IDX_W. The index is forced to 0 when no command is issued.
    w_off   = w_addr - PC_START;
    ram_idx = ram_en ? IDX_W'(w_off >> 3) : '0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for ram_port_arbiter, using the default parameters.
//
// A behavioural RAM (1-cycle read latency, bit-masked writes) is connected to
// the RAM port. A per-cycle monitor inside tick() works as the scoreboard:
//   - On each grant it checks the RAM command against the bench's own address
//     and mask math.
//   - It then pushes the expected response, computed from a reference memory
//     image kept by the bench.
//   - In the next cycle it pops that entry and compares it with the response
//     port.
// The scenario tasks drive the requests and add targeted checks of their own.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam logic [63:0] PC_START = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [23:0] ram_idx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic [63:0] ram_rdata = 64'h0;

  ram_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_idx    (ram_idx),
    .ram_wdata  (ram_wdata),
    .ram_wmask  (ram_wmask),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM, addressed by the low index bits. Every index used below
  // maps to a distinct slot, and the all-ones index lands in slot 15.
  logic [63:0] ram_mem [16] = '{default: 64'h0};

  always @(posedge clk) begin
    if (ram_en === 1'b1) begin
      if (ram_we === 1'b1) begin
        ram_mem[ram_idx[3:0]] <= (ram_mem[ram_idx[3:0]] & ~ram_wmask) |
                                 (ram_wdata & ram_wmask);
      end else begin
        ram_rdata <= ram_mem[ram_idx[3:0]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          fetch;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  bit   [63:0] ref_mem [bit [23:0]];

  int          checks = 0;
  int          errors = 0;
  bit          got_if;
  bit          got_mem;
  logic [23:0] last_idx;
  logic [63:0] last_wmask;
  logic [63:0] last_mem_rdata;
  logic [31:0] last_if_rdata;
  bit          last_resp_seen;

  function automatic logic [23:0] exp_idx(input logic [63:0] a);
    logic [63:0] d;
    d = a - PC_START;
    return d[26:3];
  endfunction

  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = m[b] ? 8'hFF : 8'h00;
    return r;
  endfunction

  // One clock cycle. Outputs are observed on the falling edge, and the call
  // returns 1 ns after the next rising edge so callers can drive new inputs.
  task automatic tick();
    exp_t        e;
    logic [23:0] ix;
    logic [63:0] w;
    @(negedge clk);
    got_if         = 1'b0;
    got_mem        = 1'b0;
    last_resp_seen = 1'b0;
    if (rst === 1'b1) begin
      exp_q.delete();
      checks++;
      if (if_gnt !== 1'b0 || if_rvalid !== 1'b0 || if_rdata !== 32'h0 ||
          mem_gnt !== 1'b0 || mem_rvalid !== 1'b0 || mem_rdata !== 64'h0 ||
          ram_en !== 1'b0 || ram_we !== 1'b0 || ram_idx !== 24'h0 ||
          ram_wdata !== 64'h0 || ram_wmask !== 64'h0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b/%b rvalid=%b/%b en=%b we=%b idx=%h, all required 0",
                 if_gnt, mem_gnt, if_rvalid, mem_rvalid, ram_en, ram_we, ram_idx);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_resp_seen = 1'b1;
      checks++;
      if (e.fetch) begin
        last_if_rdata = if_rdata;
        if (if_rvalid !== 1'b1 || mem_rvalid !== 1'b0 || if_rdata !== e.data[31:0] ||
            mem_rdata !== 64'h0) begin
          errors++;
          $display("FAIL fetch_resp: if_rvalid=%b mem_rvalid=%b if_rdata=%h, required 1/0/%h",
                   if_rvalid, mem_rvalid, if_rdata, e.data[31:0]);
        end
      end else begin
        last_mem_rdata = mem_rdata;
        if (mem_rvalid !== 1'b1 || if_rvalid !== 1'b0 || mem_rdata !== e.data ||
            if_rdata !== 32'h0) begin
          errors++;
          $display("FAIL data_resp: mem_rvalid=%b if_rvalid=%b mem_rdata=%h, required 1/0/%h",
                   mem_rvalid, if_rvalid, mem_rdata, e.data);
        end
      end
      checks++;
      if (if_gnt !== 1'b0 || mem_gnt !== 1'b0 || ram_en !== 1'b0) begin
        errors++;
        $display("FAIL resp_no_grant: if_gnt=%b mem_gnt=%b ram_en=%b, required 0",
                 if_gnt, mem_gnt, ram_en);
      end
    end else begin
      checks++;
      if (if_rvalid !== 1'b0 || mem_rvalid !== 1'b0 || if_rdata !== 32'h0 ||
          mem_rdata !== 64'h0) begin
        errors++;
        $display("FAIL idle_rdata: rvalid=%b/%b if_rdata=%h mem_rdata=%h, required 0",
                 if_rvalid, mem_rvalid, if_rdata, mem_rdata);
      end
      if (mem_gnt === 1'b1) begin
        got_mem    = 1'b1;
        ix         = exp_idx(mem_addr);
        last_idx   = ram_idx;
        last_wmask = ram_wmask;
        checks++;
        if (mem_req !== 1'b1 || if_gnt !== 1'b0 || ram_en !== 1'b1 ||
            ram_we !== mem_we || ram_idx !== ix ||
            (mem_we && (ram_wmask !== expand(mem_wmask) || ram_wdata !== mem_wdata))) begin
          errors++;
          $display("FAIL data_cmd: en=%b we=%b idx=%h wmask=%h, required 1/%b/%h/%h",
                   ram_en, ram_we, ram_idx, ram_wmask, mem_we, ix,
                   mem_we ? expand(mem_wmask) : 64'h0);
        end
        e.fetch = 1'b0;
        if (mem_we) begin
          e.data      = 64'h0;
          ref_mem[ix] = (ref_mem[ix] & ~expand(mem_wmask)) | (mem_wdata & expand(mem_wmask));
        end else begin
          e.data = ref_mem[ix];
        end
        exp_q.push_back(e);
      end else if (if_gnt === 1'b1) begin
        got_if   = 1'b1;
        ix       = exp_idx(if_addr);
        last_idx = ram_idx;
        checks++;
        if (if_req !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_idx !== ix) begin
          errors++;
          $display("FAIL fetch_cmd: en=%b we=%b idx=%h, required 1/0/%h",
                   ram_en, ram_we, ram_idx, ix);
        end
        w       = ref_mem[ix];
        e.fetch = 1'b1;
        e.data  = {32'h0, (if_addr[2] ? w[63:32] : w[31:0])};
        exp_q.push_back(e);
      end else begin
        checks++;
        if (ram_en !== 1'b0 || (mem_req === 1'b1) || (if_req === 1'b1)) begin
          errors++;
          $display("FAIL missing_grant: ram_en=%b if_req=%b mem_req=%b with no grant in IDLE",
                   ram_en, if_req, mem_req);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit fetch);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (fetch ? got_if : got_mem) return;
    end
    checks++;
    errors++;
    $display("FAIL gnt_timeout: %s grant not seen within 8 cycles, required a grant",
             fetch ? "fetch" : "data");
  endtask

  task automatic do_load(input logic [63:0] a);
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = a;
    wait_gnt(1'b0);
    mem_req = 1'b0;
    tick();
  endtask

  task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    wait_gnt(1'b0);
    mem_req = 1'b0;
    mem_we  = 1'b0;
    tick();
  endtask

  task automatic do_fetch(input logic [63:0] a);
    if_req  = 1'b1;
    if_addr = a;
    wait_gnt(1'b1);
    if_req = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    if_req    = 1'b1;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    if_addr   = 64'h8000_0008;
    mem_addr  = 64'h8000_0010;
    mem_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_wmask = 8'hFF;
    tick();
    tick();
    if_req    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 64'h0;
    mem_wmask = 8'h0;
    rst       = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    do_store(64'h8000_0000, 64'h1111_2222_3333_4444, 8'hFF);
    do_fetch(64'h8000_0004);
    checks++;
    if (last_if_rdata !== 32'h1111_2222 || last_idx !== 24'h0) begin
      errors++;
      $display("FAIL fetch_hi: if_rdata=%h idx=%h, required 11112222/000000",
               last_if_rdata, last_idx);
    end
    do_fetch(64'h8000_0000);
    checks++;
    if (last_if_rdata !== 32'h3333_4444) begin
      errors++;
      $display("FAIL fetch_lo: if_rdata=%h, required 33334444", last_if_rdata);
    end
  endtask

  task automatic test_store_load();
    do_store(64'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    checks++;
    if (last_wmask !== 64'h0000_0000_FFFF_FFFF || last_idx !== 24'd2) begin
      errors++;
      $display("FAIL store_mask: wmask=%h idx=%h, required 00000000ffffffff/000002",
               last_wmask, last_idx);
    end
    do_load(64'h8000_0010);
    checks++;
    if (last_mem_rdata !== 64'h0000_0000_CCCC_DDDD) begin
      errors++;
      $display("FAIL store_reload: mem_rdata=%h, required 00000000ccccdddd", last_mem_rdata);
    end
    // Sparse mask over a populated word; the low address bits are ignored.
    do_store(64'h8000_0018, 64'h0123_4567_89AB_CDEF, 8'hFF);
    do_store(64'h8000_001F, 64'hFFFF_FFFF_FFFF_FFFF, 8'hA5);
    do_load(64'h8000_0018);
    checks++;
    if (last_mem_rdata !== 64'hFF23_FF67_89FF_CDFF) begin
      errors++;
      $display("FAIL sparse_mask: mem_rdata=%h, required ff23ff6789ffcdff", last_mem_rdata);
    end
  endtask

  task automatic test_collision();
    int mem_at = -1;
    int if_at  = -1;
    if_addr  = 64'h8000_0000;
    mem_addr = 64'h8000_0010;
    mem_we   = 1'b0;
    if_req   = 1'b1;
    mem_req  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (got_mem && mem_at < 0) begin
        mem_at  = k;
        mem_req = 1'b0;
      end
      if (got_if && if_at < 0) begin
        if_at  = k;
        if_req = 1'b0;
      end
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    checks++;
    if (mem_at != 0 || if_at != 2) begin
      errors++;
      $display("FAIL collision: mem_gnt at %0d if_gnt at %0d, required 0 and 2", mem_at, if_at);
    end
  endtask

  task automatic test_back_to_back();
    int at[4];
    int n = 0;
    mem_we   = 1'b0;
    mem_addr = 64'h8000_0000;
    mem_req  = 1'b1;
    for (int k = 0; k < 12 && n < 4; k++) begin
      tick();
      if (got_mem) begin
        at[n]    = k;
        n++;
        mem_addr = 64'h8000_0000 + 64'(n) * 64'h8;
        if (n == 4) mem_req = 1'b0;
      end
    end
    mem_req = 1'b0;
    tick();
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL b2b_count: %0d grants, required 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (at[i] != 2 * i) begin
        errors++;
        $display("FAIL b2b_spacing: grant %0d at cycle %0d, required %0d", i, at[i], 2 * i);
      end
    end
  endtask

  task automatic test_starvation();
    int n_if = 0;
    bit exp_f;
    if_addr  = 64'h8000_0000;
    mem_addr = 64'h8000_0018;
    mem_we   = 1'b0;
    if_req   = 1'b1;
    mem_req  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
`ifdef ARB_STARVE_GUARD_EN
      exp_f = (k == 8);
`else
      exp_f = 1'b0;
`endif
      if (got_if) n_if++;
      if (k % 2 == 0) begin
        checks++;
        if (got_if !== exp_f || got_mem !== !exp_f) begin
          errors++;
          $display("FAIL starve_grant: cycle %0d if_gnt=%b mem_gnt=%b, required %b/%b",
                   k, got_if, got_mem, exp_f, !exp_f);
        end
      end
    end
    checks++;
`ifdef ARB_STARVE_GUARD_EN
    if (n_if != 1) begin
`else
    if (n_if != 0) begin
`endif
      errors++;
      $display("FAIL starve_count: %0d fetch grants in 12 cycles", n_if);
    end
    mem_req = 1'b0;
    wait_gnt(1'b1);
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_we   = 1'b0;
    mem_addr = 64'h8000_0010;
    mem_req  = 1'b1;
    wait_gnt(1'b0);
    mem_req = 1'b0;
    rst     = 1'b1;
    tick();
    checks++;
    if (mem_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rvalid: mem_rvalid=%b, required 0", mem_rvalid);
    end
    rst = 1'b0;
    tick();
    do_load(64'h8000_0010);
    checks++;
    if (last_resp_seen !== 1'b1 || last_mem_rdata !== 64'h0000_0000_CCCC_DDDD) begin
      errors++;
      $display("FAIL reset_mid_after: mem_rdata=%h, required 00000000ccccdddd", last_mem_rdata);
    end
  endtask

  task automatic test_wrap();
    do_store(64'h7FFF_FFF8, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    checks++;
    if (last_idx !== 24'hFF_FFFF) begin
      errors++;
      $display("FAIL wrap_store_idx: idx=%h, required ffffff", last_idx);
    end
    do_load(64'h7FFF_FFF8);
    checks++;
    if (last_idx !== 24'hFF_FFFF || last_mem_rdata !== 64'hDEAD_BEEF_0BAD_F00D) begin
      errors++;
      $display("FAIL wrap_load: idx=%h rdata=%h, required ffffff/deadbeef0badf00d",
               last_idx, last_mem_rdata);
    end
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = 64'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 64'h0;
    mem_wdata = 64'h0;
    mem_wmask = 8'h0;
    #1;
    test_reset();
    test_fetch();
    test_store_load();
    test_collision();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    test_wrap();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares a single 64-bit, one-command-per-cycle RAM port between the instruction-fetch requester and the load/store requester of the CPU core.
- Sits between IF/MEM stages and the RAM model.
- Handles arbitration, base-relative word addressing, instruction half-word selection and response sequencing.
- One transaction is outstanding at a time; the RAM read latency is fixed at 1 cycle.

Parameters:
- ADDR_W, 64, requester byte-address width
- PC_START, 64'h8000_0000, byte address mapped to RAM word 0
- IDX_W, 24, RAM word-index width
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (only used with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch byte address, 4-byte aligned
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch response pulse
- if_rdata  out  32  instruction word
- mem_req  in  1  data request, held until mem_gnt
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data byte address; bits [2:0] ignored
- mem_wdata  in  64  store data, lane-aligned
- mem_wmask  in  8  byte-lane enables for store
- mem_gnt  out  1  data accepted this cycle
- mem_rvalid  out  1  data response pulse (load data or store ack)
- mem_rdata  out  64  load word
- ram_en  out  1  RAM command valid
- ram_we  out  1  RAM write
- ram_idx  out  IDX_W  word index = (addr - PC_START) >> 3, truncated to IDX_W
- ram_wdata  out  64  write data
- ram_wmask  out  64  bit mask, each mask bit replicated x8
- ram_rdata  in  64  read data, valid 1 cycle after a read command

Behaviour:
- FSM states:
  - IDLE: can grant.
  - RESP_I: fetch response cycle.
  - RESP_D: data response cycle.
- Reset state is IDLE. While rst is high, all outputs are 0: gnt, rvalid, ram_en, ram_we, rdata, ram_idx, ram_wdata, ram_wmask.
- Arbitration happens only in IDLE and is combinational:
  - Default is fixed data priority: mem_req wins over if_req.
  - Grant and RAM command occur in the same cycle: ram_en=1, ram_idx from the winning address.
  - ram_we = mem_we for a data grant, 0 for a fetch grant.
- On a grant:
  - Register the winner and the transaction type, plus if_addr[2] for fetches.
  - Go to RESP_I or RESP_D.
- RESP_I (1 cycle):
  - if_rvalid=1.
  - if_rdata = if_addr[2] latched ? ram_rdata[63:32] : ram_rdata[31:0].
  - No grant this cycle; go to IDLE.
- RESP_D (1 cycle):
  - mem_rvalid=1.
  - mem_rdata = ram_rdata for loads, 0 for stores.
  - No grant; go to IDLE.
- Throughput: one transaction per 2 cycles. Latency from grant to rvalid is exactly 1 cycle.
- The write is committed by the RAM at the grant-cycle clock edge. The arbiter inserts no read-modify-write; a byte with a 0 mask bit is untouched.
- rdata outputs are 0 in every cycle where the matching rvalid is 0.
- Requests seen in RESP_* are ignored; requesters keep holding them until granted.
- Address below PC_START: index wraps modulo 2^IDX_W. No error is raised.
- Reset asserted mid-transaction: the state returns to IDLE at once and a pending rvalid is dropped. No response is ever issued for that transaction.
- Simultaneous requests in IDLE: data is granted; fetch is granted at the next IDLE (3rd cycle) if still requested.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A saturating counter counts consecutive data grants made while if_req=1.
  - When count == STARVE_LIMIT and both requests are present in IDLE, fetch is granted instead.
  - The counter clears on any fetch grant, on if_req=0 in IDLE, and on reset.
- Undefined: no counter; strict data priority as above.

Test Plan:
- Fetch alone: if_req=1, if_addr=0x8000_0004, ram word0=0x1111_2222_3333_4444 -> if_gnt cycle 0, ram_idx=0; if_rvalid cycle 1, if_rdata=0x1111_2222.
- Store then load: mem_we=1, addr=0x8000_0010, wmask=0x0F, wdata=0xAAAA_BBBB_CCCC_DDDD over word 0 -> ram_wmask=0x0000_0000_FFFF_FFFF; ack mem_rvalid, mem_rdata=0; reload returns 0x0000_0000_CCCC_DDDD with prior upper half kept (word index 2).
- Collision: if_req and mem_req both rise in cycle 0 -> mem_gnt cycle 0, mem_rvalid cycle 1, if_gnt cycle 2, if_rvalid cycle 3.
- Reset mid-transaction: rst pulsed in the RESP_D cycle after a load grant -> no mem_rvalid; all outputs 0; the next request is granted normally after release.
- Starvation with ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: mem_req and if_req held continuously -> 4 data grants, then if_gnt, then data again. Without the macro, if_gnt is never asserted.
- Wrap: mem_addr=0x7FFF_FFF8 load -> ram_idx = all ones (2^IDX_W-1).
